// File: rtl/instr_encode_if.sv
// Request/response bundle for the RV32I instruction encoder.
// master drives requests and consumes words; slave is the encoder.
interface instr_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, opcode, rd, rs1, rs2, func3, func7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, func3, func7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_encode_unit.sv
// Packs decoded RV32I fields plus a sign-extended immediate back into an
// instruction word; one register stage (S1) feeding a 2-entry output FIFO.
module instr_encode_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_flush,
  instr_encode_if.slave    bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [7:0]       err_count
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CW      = 2;
  localparam int unsigned IW      = 32;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [IW-1:0] NOP_INSTR = 32'h0000_0013;

  logic [IW-1:0] enc_word;
  logic          enc_legal;
  logic          fits_12;
  logic          fits_13;
  logic          fits_21;

  logic          s1_valid;
  logic [IW-1:0] s1_instr;
  logic          s1_err;

  logic [IW-1:0] fifo_instr [DEPTH];
  logic          fifo_err   [DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [CW-1:0] fifo_count;

  logic          ready_c;
  logic          accept_c;
  logic          push_c;
  logic          pop_c;
  logic          fifo_has_room_c;

  // Immediate range checks: upper bits must be pure sign extension.
  assign fits_12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign fits_13 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign fits_21 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  always_comb begin
    enc_word  = NOP_INSTR;
    enc_legal = 1'b0;
    unique case (bus.opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        enc_legal = fits_12;
        enc_word  = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
      end
      OP_STORE: begin
        enc_legal = fits_12;
        enc_word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.func3,
                     bus.imm[4:0], bus.opcode};
      end
      OP_BRANCH: begin
        enc_legal = fits_13 & ~bus.imm[0];
        enc_word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.func3,
                     bus.imm[4:1], bus.imm[11], bus.opcode};
      end
      OP_JAL: begin
        enc_legal = fits_21 & ~bus.imm[0];
        enc_word  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                     bus.rd, bus.opcode};
      end
      OP_LUI, OP_AUIPC: begin
        enc_legal = ~(|bus.imm[11:0]);
        enc_word  = {bus.imm[31:12], bus.rd, bus.opcode};
      end
      OP_REG: begin
        enc_legal = 1'b1;
        enc_word  = {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
      end
      default: begin
        enc_legal = 1'b0;
        enc_word  = NOP_INSTR;
      end
    endcase
    if (!enc_legal) begin
      enc_word = NOP_INSTR;
    end
  end

  // Handshake decisions use only registered occupancy, never out_ready.
  assign fifo_has_room_c = (fifo_count < CW'(DEPTH));
  assign ready_c         = ~enc_flush & (~s1_valid | fifo_has_room_c);
  assign accept_c        = bus.in_valid & ready_c;
  assign push_c          = s1_valid & fifo_has_room_c;
  assign pop_c           = (fifo_count != '0) & bus.out_ready;

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_instr = fifo_instr[rd_ptr];
  assign bus.out_err   = (fifo_count != '0) & fifo_err[rd_ptr];

  // S1 register: loads on accept, may reload in the same cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_err   <= 1'b0;
    end else if (enc_flush) begin
      s1_valid <= 1'b0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_instr <= enc_word;
      s1_err   <= ~enc_legal;
    end else if (push_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Output FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_err[i]   <= 1'b0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else if (enc_flush) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push_c) begin
        fifo_instr[wr_ptr] <= s1_instr;
        fifo_err[wr_ptr]   <= s1_err;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop_c) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Accept counters: legal count wraps, illegal count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (accept_c) begin
      if (enc_legal) begin
        enc_count <= enc_count + CNT_W'(1);
      end else if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/instr_encode_unit.md
# instr_encode_unit

Packs decoded RISC-V RV32I instruction fields and a 32-bit immediate back into a 32-bit instruction word. It is the inverse of the pipeline's immediate-generation decoder. It sits on the debug/instruction-injection path: a request source supplies fields over a valid/ready handshake, and the block emits encoded words through a registered stage and a 2-entry output FIFO. Immediates are range- and alignment-checked; illegal requests produce a NOP with an error flag.

## Interface
- CNT_W, 16, width of the accepted-instruction counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enc_flush  in  1  synchronous flush of the internal stage and FIFO
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- opcode  in  7  instruction opcode
- rd, rs1, rs2  in  5 each  register indices
- func3  in  3  funct3
- func7  in  7  funct7; used for R-type only
- imm  in  32  full sign-extended immediate, in the same form the decoder produces
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer ready; pop when out_valid && out_ready
- out_instr  out  32  encoded instruction at FIFO head
- out_err  out  1  head entry was an illegal request
- enc_count  out  CNT_W  legal requests accepted; wraps
- err_count  out  8  illegal requests accepted; saturates at 255

## Operation
- Encoding by opcode, with fields in standard positions (opcode[6:0], rd[11:7], func3[14:12], rs1[19:15], rs2[24:20]):
  - I (0010011, 0000011, 1100111): instr[31:20]=imm[11:0].
  - S (0100011): {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - U (0110111, 0010111): {imm[31:12], rd, opcode}.
  - R (0110011): {func7, rs2, rs1, func3, rd, opcode}; imm ignored.
- Legality checks:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - Any other opcode is illegal.
- Illegal request: the entry is out_instr=32'h00000013 with out_err=1.
- Round-trip property: for every legal request, decoding out_instr yields imm exactly.
- Stage S1 (s1_valid, s1_instr, s1_err) loads on accept.
- S1 moves into the FIFO when s1_valid && fifo_count<2, evaluated on count before any same-cycle pop.
- in_ready = !enc_flush && (!s1_valid || fifo_count<2). It is registered-state only, with no combinational path from out_ready.
- S1 may load a new request in the same cycle it drains.
- Counters update at accept: enc_count+1 if legal; err_count+1 (saturating) if illegal.
- enc_flush clears s1_valid and the FIFO (count, pointers) next edge. No accept occurs that cycle. Counters are unaffected.

## Timing
- Reset (async, rst_n=0): s1_valid=0, fifo_count=0, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0, in_ready=1.
- Latency: accept at edge N → out_valid=1 after edge N+1 (FIFO empty, out_ready don't-care).
- Throughput: one instruction per cycle while out_ready=1.
- Backpressure capacity: 3 requests (S1 + 2 FIFO) before in_ready drops.
- FIFO full with a pop: the pop happens, the push is deferred one cycle, and in_ready rises the cycle after the pop.
- Ordering: strict FIFO; out_instr/out_err stable while out_valid && !out_ready.
- Counter boundaries: enc_count wraps 2^CNT_W-1 → 0; err_count holds at 255.
- rst_n mid-transfer discards all entries immediately.

## Test plan
- ADDI: opcode=0010011, rd=1, rs1=0, func3=0, imm=32'hFFFFFFFF → out_instr=32'hFFF00093, out_err=0, two edges after accept; enc_count=1.
- SW and BEQ back-to-back, out_ready=1:
  - SW: opcode=0100011, rs1=1, rs2=2, func3=010, imm=8 → 32'h0020A423.
  - BEQ: opcode=1100011, rs1=rs2=0, imm=-4 → 32'hFE000EE3, on consecutive cycles.
- JAL and LUI:
  - JAL: rd=1, imm=32'h00000800 → 32'h001000EF.
  - LUI: rd=5, imm=32'h12345000 → 32'h123452B7.
- Illegal requests:
  - BEQ imm=3 → 32'h00000013, out_err=1, err_count=1.
  - ADDI imm=32'h00000800 → out_err=1.
  - Opcode 1110011 → out_err=1.
  - err_count saturates at 255 after 300 illegal requests.
- Backpressure: out_ready=0, in_valid=1 with 5 distinct requests → exactly 3 accepted, then in_ready=0. Raise out_ready → the 3 emerge in order, and the remaining 2 are accepted as space frees.
- Flush and reset:
  - enc_flush with 3 entries held → out_valid=0 next cycle, in_ready=1, counters unchanged.
  - rst_n pulsed low mid-stream → all outputs reset asynchronously.
